// File: rtl/arb_pkg.sv
// Shared arbiter types and the MSB-first decoder convention (index n drives bit 7-n).
package arb_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [ARB_N-1:0] idx_to_onehot(input logic [ARB_IDX_W-1:0] idx);
    return {1'b1, {(ARB_N-1){1'b0}}} >> idx;
  endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Combinational round-robin search: first requesting index after ptr, wrapping through ptr,
// optionally skipping the current holder.
module rr_pick_8
  import arb_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  input  logic       excl,
  input  logic [2:0] excl_idx,
  output logic       found,
  output logic [2:0] idx
);

  logic [2:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    // k = 8 wraps back onto ptr itself, so the old owner is considered last
    for (int k = 1; k <= ARB_N; k++) begin
      cand = ptr + 3'(k);
      if (!found && (|(req & idx_to_onehot(cand))) && !(excl && (cand == excl_idx))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot/index grant and a maximum hold time.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  // With no limit the counter simply parks at its maximum and never triggers a rotation
  localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'hFF : 8'(HOLD_MAX - 1);

  arb_state_t state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;

  logic       holder_req;
  logic       others;
  logic       force_rot;
  logic       excl;
  logic       found;
  logic [2:0] pick_idx;
  logic       regrant;
  logic       go_idle;

  assign holder_req = |(req & idx_to_onehot(ptr));
  assign others     = |(req & ~idx_to_onehot(ptr));
  assign force_rot  = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST) && others;
  assign excl       = (state == ARB_GRANT);

  rr_pick_8 u_pick (
    .req      (req),
    .ptr      (ptr),
    .excl     (excl),
    .excl_idx (ptr),
    .found    (found),
    .idx      (pick_idx)
  );

  always_comb begin
    regrant = 1'b0;
    go_idle = 1'b0;
    case (state)
      ARB_IDLE: regrant = found;
      ARB_GRANT: begin
        if (!holder_req) begin
          regrant = found;
          go_idle = !found;
        end else if (force_rot) begin
          regrant = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  // Grant register stage: one-hot comes straight from the chosen index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      ptr       <= 3'd7;
      hold_cnt  <= 8'd0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
    end else if (regrant) begin
      state     <= ARB_GRANT;
      ptr       <= pick_idx;
      hold_cnt  <= 8'd0;
      gnt       <= idx_to_onehot(pick_idx);
      gnt_idx   <= pick_idx;
      gnt_valid <= 1'b1;
    end else if (go_idle) begin
      state     <= ARB_IDLE;
      gnt       <= 8'h00;
      gnt_valid <= 1'b0;
    end else if ((state == ARB_GRANT) && (hold_cnt != HOLD_LAST)) begin
      hold_cnt  <= hold_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: one instance with HOLD_MAX=3, one with no hold limit.
module tb_rr_arbiter_8;

  typedef struct {
    int         tag;
    bit         dut_b;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    string      name;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_a = 8'h00;
  logic [7:0] req_b = 8'h00;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] idx_a, idx_b;
  logic       vld_a, vld_b;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  exp_t sq[$];
  exp_t aq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rr_arbiter_8 #(.HOLD_MAX(3)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_a),
    .gnt       (gnt_a),
    .gnt_idx   (idx_a),
    .gnt_valid (vld_a)
  );

  rr_arbiter_8 #(.HOLD_MAX(0)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_b),
    .gnt       (gnt_b),
    .gnt_idx   (idx_b),
    .gnt_valid (vld_b)
  );

  task automatic compare(input exp_t e);
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
    g = e.dut_b ? gnt_b : gnt_a;
    i = e.dut_b ? idx_b : idx_a;
    v = e.dut_b ? vld_b : vld_a;
    checks++;
    if (g !== e.gnt || i !== e.idx || v !== e.vld) begin
      errors++;
      $display("FAIL %s (dut_%s, cyc %0d): got gnt=%h idx=%0d vld=%b, expected gnt=%h idx=%0d vld=%b",
               e.name, e.dut_b ? "b" : "a", cyc, g, i, v, e.gnt, e.idx, e.vld);
    end
  endtask

  task automatic check_inv(input string name, input logic [7:0] g, input logic [2:0] i, input logic v);
    logic [7:0] want;
    want = v ? (8'h80 >> i) : 8'h00;
    checks++;
    if (v !== (|g) || g !== want) begin
      errors++;
      $display("FAIL %s (cyc %0d): got gnt=%h idx=%0d vld=%b, expected gnt=%h and vld=|gnt",
               name, cyc, g, i, v, want);
    end
  endtask

  task automatic push(input bit b, input logic [7:0] g, input logic [2:0] i, input logic v, input string n);
    exp_t e;
    e.tag = cyc + 1; e.dut_b = b; e.gnt = g; e.idx = i; e.vld = v; e.name = n;
    sq.push_back(e);
  endtask

  task automatic push_async(input bit b, input string n);
    exp_t e;
    e.tag = cyc; e.dut_b = b; e.gnt = 8'h00; e.idx = 3'd0; e.vld = 1'b0; e.name = n;
    aq.push_back(e);
  endtask

  // Edge monitor: pops every expectation due at this edge, plus output invariants
  always @(posedge clk) begin
    exp_t e;
    #1;
    while (sq.size() > 0 && sq[0].tag <= cyc) begin
      e = sq.pop_front();
      if (e.tag < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: stale expectation tag=%0d at cyc=%0d", e.name, e.tag, cyc);
      end else begin
        compare(e);
      end
    end
    check_inv("inv_a", gnt_a, idx_a, vld_a);
    check_inv("inv_b", gnt_b, idx_b, vld_b);
  end

  // Asynchronous reset monitor: outputs must clear without waiting for a clock edge
  always @(negedge rst_n) begin
    #1;
    while (aq.size() > 0) compare(aq.pop_front());
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ix;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    push(0, 8'h00, 3'd0, 1'b0, "rst_a");
    push(1, 8'h00, 3'd0, 1'b0, "rst_b");
    @(negedge clk);
    rst_n = 1'b1;

    // idle after reset, then a single request
    repeat (5) begin
      push(0, 8'h00, 3'd0, 1'b0, "t1_idle_a");
      push(1, 8'h00, 3'd0, 1'b0, "t1_idle_b");
      @(negedge clk);
    end
    req_a = 8'h20; push(0, 8'h20, 3'd2, 1'b1, "t1_grant2"); @(negedge clk);

    // holder drop hands over with wrap 5 -> 1
    req_a = 8'h04; push(0, 8'h04, 3'd5, 1'b1, "t3_setup5"); @(negedge clk);
    req_a = 8'h44; push(0, 8'h04, 3'd5, 1'b1, "t3_hold5");  @(negedge clk);
    req_a = 8'h40; push(0, 8'h40, 3'd1, 1'b1, "t3_wrap1");  @(negedge clk);

    // lone requester keeps the grant past HOLD_MAX, then yields once someone else asks
    req_a = 8'h10; push(0, 8'h10, 3'd3, 1'b1, "t4_grant3"); @(negedge clk);
    repeat (20) begin
      push(0, 8'h10, 3'd3, 1'b1, "t4_alone"); @(negedge clk);
    end
    req_a = 8'h90; push(0, 8'h80, 3'd0, 1'b1, "t4_force0"); @(negedge clk);

    // all requesting: 0 finishes its 3 cycles, then 1..7,0,1 for 3 cycles each
    req_a = 8'hFF;
    push(0, 8'h80, 3'd0, 1'b1, "t2_hold0"); @(negedge clk);
    push(0, 8'h80, 3'd0, 1'b1, "t2_hold0"); @(negedge clk);
    for (int r = 1; r <= 9; r++) begin
      ix = 3'(r % 8);
      for (int c = 0; c < 3; c++) begin
        push(0, 8'h80 >> ix, ix, 1'b1, "t2_rotate"); @(negedge clk);
      end
    end

    // holder drops with nobody else: idle, index held
    req_a = 8'h00; push(0, 8'h00, 3'd1, 1'b0, "t_idle_keep"); @(negedge clk);

    // unlimited hold
    req_b = 8'hC0; push(1, 8'h80, 3'd0, 1'b1, "t5_grant0"); @(negedge clk);
    repeat (100) begin
      push(1, 8'h80, 3'd0, 1'b1, "t5_hold0"); @(negedge clk);
    end
    req_b = 8'h40; push(1, 8'h40, 3'd1, 1'b1, "t5_drop"); @(negedge clk);
    req_b = 8'h00; push(1, 8'h00, 3'd1, 1'b0, "t5_idle"); @(negedge clk);

    // asynchronous reset mid-cycle while requester 6 holds
    req_a = 8'h02; push(0, 8'h02, 3'd6, 1'b1, "t6_setup6"); @(negedge clk);
    #2;
    push_async(0, "t6_async_a");
    push_async(1, "t6_async_b");
    rst_n = 1'b0;
    push(0, 8'h00, 3'd0, 1'b0, "t6_in_reset");
    @(negedge clk);
    req_a = 8'hFF;
    rst_n = 1'b1;
    push(0, 8'h80, 3'd0, 1'b1, "t6_first0"); @(negedge clk);
    repeat (2) @(negedge clk);

    if (sq.size() != 0 || aq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d edge and %0d async expectations never checked", sq.size(), aq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
